hazard_stall_controller: RTL

- Central hazard and sequencing controller for the 5-stage MIPS pipeline (F, D, E, M, W). The pipeline resolves data hazards by stalling only; there is no forwarding.
- Keeps a shadow scoreboard of the destination registers held in E, M and W. Compares the D-stage source registers against that scoreboard.
- Drives the stall, bubble and flush controls, the per-stage hazard indicators, and performance counters.
- Sits beside the datapath inside top2 and replaces ad-hoc stall logic.

---
 rtl/hazard_stall_controller_pkg.sv | 18 +
 rtl/hazard_sat_counter.sv | 19 +
 rtl/hazard_stall_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// This file holds the default register width, the scoreboard stage indices and the zero-register id.
package hazard_stall_controller_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_STG  = 3;

    // Scoreboard entry index per downstream stage
    localparam int STG_E    = 0;
    localparam int STG_M    = 1;
    localparam int STG_W    = 2;

    localparam int REG_ZERO = 0;

    // Entry layout, MSB first: {valid, regwrite, dest}
    localparam int ENT_META_W = 2;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter. It counts up on inc and holds at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall-only hazard controller for the 5-stage pipeline: a shadow scoreboard of E/M/W
// destinations is checked against the D-stage sources to produce the stall/flush controls.
module hazard_stall_controller #(
    parameter int REG_AW         = hazard_stall_controller_pkg::REG_AW,
    parameter bit WB_WRITE_FIRST = 1'b1,
    parameter int CNT_W          = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InstrValidD,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              UseRsD,
    input  logic              UseRtD,
    input  logic              RegWriteD,
    input  logic [REG_AW-1:0] WriteRegD,
    input  logic              BranchTakenD,
    output logic              Stall,
    output logic              FlushE,
    output logic              FlushD,
    output logic              hazardTypeE,
    output logic              hazardTypeM,
    output logic              hazardTypeW,
    output logic              RegWriteE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushCount
);

    import hazard_stall_controller_pkg::NUM_STG;
    import hazard_stall_controller_pkg::STG_E;
    import hazard_stall_controller_pkg::STG_M;
    import hazard_stall_controller_pkg::STG_W;
    import hazard_stall_controller_pkg::REG_ZERO;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] dest;
    } entry_t;

    entry_t sb [NUM_STG];
    logic   match [NUM_STG];

    // A stalled or empty D slot enters E as an all-zero bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < NUM_STG; s++) begin
                sb[s] <= '0;
            end
        end else begin
            sb[STG_W] <= sb[STG_M];
            sb[STG_M] <= sb[STG_E];
            if (Stall || !InstrValidD) begin
                sb[STG_E] <= '0;
            end else begin
                sb[STG_E] <= '{valid: 1'b1, regwrite: RegWriteD, dest: WriteRegD};
            end
        end
    end

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    always_comb begin
        for (int s = 0; s < NUM_STG; s++) begin
            match[s] = sb[s].valid && sb[s].regwrite &&
                       (sb[s].dest != REG_AW'(REG_ZERO)) &&
                       ((UseRsD && (RsD == sb[s].dest)) ||
                        (UseRtD && (RtD == sb[s].dest)));
        end
    end

    assign hazardTypeE = InstrValidD && match[STG_E];
    assign hazardTypeM = InstrValidD && match[STG_M];
    assign hazardTypeW = InstrValidD && match[STG_W] && !WB_WRITE_FIRST;

    assign Stall  = hazardTypeE || hazardTypeM || hazardTypeW;
    assign FlushE = Stall;
    // A stalled branch has not resolved yet, so stall wins over redirect.
    assign FlushD = BranchTakenD && InstrValidD && !Stall;

    assign RegWriteE = sb[STG_E].regwrite;
    assign RegWriteM = sb[STG_M].regwrite;
    assign RegWriteW = sb[STG_W].regwrite;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (Stall),
        .count (StallCycles)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (FlushD),
        .count (FlushCount)
    );

endmodule
